// File: rtl/ahb_irq_arbiter_if.sv
//------------------------------------------------------------------------------
// ahb_irq_arbiter_if
// Purpose : AHB-Lite bus bundle between a bus master and the interrupt arbiter
//           register slave.
// Signals : HSEL, HREADY, HADDR[31:0], HTRANS[1:0], HWRITE, HSIZE[2:0],
//           HWDATA[31:0]   master -> slave
//           HRDATA[31:0], HREADYOUT, HRESP   slave -> master
// Modports: master (drives requests), slave (drives responses)
//------------------------------------------------------------------------------
interface ahb_irq_arbiter_if;
    logic        HSEL;
    logic        HREADY;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        HREADYOUT;
    logic        HRESP;

    modport master (
        output HSEL, HREADY, HADDR, HTRANS, HWRITE, HSIZE, HWDATA,
        input  HRDATA, HREADYOUT, HRESP
    );

    modport slave (
        input  HSEL, HREADY, HADDR, HTRANS, HWRITE, HSIZE, HWDATA,
        output HRDATA, HREADYOUT, HRESP
    );
endinterface

// File: rtl/ahb_irq_arbiter.sv
//------------------------------------------------------------------------------
// ahb_irq_arbiter
// Purpose : Collects eight asynchronous interrupt lines into a pending register,
//           masks them and grants one at a time to the CPU in round-robin order.
//           Software acknowledges a grant by writing its id to the ACK register.
// Ports   : HCLK          system clock, all state on rising edge
//           HRESETn       asynchronous active-low reset
//           ahb           AHB-Lite slave (zero wait states, always OKAY)
//           IRQ_IN[7:0]   peripheral interrupt lines, asynchronous to HCLK
//           IRQ_OUT       registered interrupt request to the CPU
//           IRQ_ID[2:0]   registered index of the granted source
// Registers (HADDR[3:2]):
//           0x0 PENDING  R / write-1-to-clear
//           0x4 MASK     RW, 8 bits
//           0x8 STATUS   R: bit8 = grant valid, bits2:0 = IRQ_ID
//           0xC ACK      W: bits2:0 = id being acknowledged
// Macro   : IRQ_EDGE_EN  when defined, a pending bit sets only on a rising edge
//           of its synchronised input; when undefined (default) pending is
//           level-sensitive.
//------------------------------------------------------------------------------
module ahb_irq_arbiter (
    input  logic               HCLK,
    input  logic               HRESETn,
    ahb_irq_arbiter_if.slave   ahb,
    input  logic [7:0]         IRQ_IN,
    output logic               IRQ_OUT,
    output logic [2:0]         IRQ_ID
);

    typedef enum logic [1:0] {
        REG_PENDING = 2'd0,
        REG_MASK    = 2'd1,
        REG_STATUS  = 2'd2,
        REG_ACK     = 2'd3
    } reg_sel_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_e;

    logic       addr_phase;
    logic       dp_valid;
    logic       dp_write;
    reg_sel_e   dp_reg;

    logic [7:0] sync1;
    logic [7:0] sync2;
    logic [7:0] set_vec;
    logic [7:0] clr_vec;
    logic [7:0] pending;
    logic [7:0] pending_nxt;
    logic [7:0] mask;
    logic [7:0] mask_nxt;
    logic [7:0] req;
    logic [7:0] wbyte;
    logic       wr_en;
    logic       ack_hit;
    logic [2:0] rr;
    logic [2:0] grant_idx;
    logic       grant_found;
    state_e     state;
    logic       unused_bus;

    //--------------------------------------------------------------------------
    // Bus address phase: capture the register select for the following data
    // phase. HREADYOUT is always 1, so every data phase lasts one cycle.
    //--------------------------------------------------------------------------
    assign addr_phase = ahb.HSEL & ahb.HREADY & ahb.HTRANS[1];

    // NOTE: state is updated with non-blocking (<=) assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            dp_valid <= 1'b0;
            dp_write <= 1'b0;
            dp_reg   <= REG_PENDING;
        end else begin
            dp_valid <= addr_phase;
            if (addr_phase) begin
                dp_write <= ahb.HWRITE;
                dp_reg   <= reg_sel_e'(ahb.HADDR[3:2]);
            end
        end
    end

    assign wr_en   = dp_valid & dp_write;
    assign wbyte   = ahb.HWDATA[7:0];
    assign ack_hit = wr_en && (dp_reg == REG_ACK) && (state == ST_GRANT)
                     && (wbyte[2:0] == IRQ_ID);

    //--------------------------------------------------------------------------
    // Input synchronisers and pending-set detection
    //--------------------------------------------------------------------------
    // NOTE: the synchroniser flops are reset along with everything else so a
    // line held high through reset cannot leak a pending bit past release.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            sync1 <= 8'h00;
            sync2 <= 8'h00;
        end else begin
            sync1 <= IRQ_IN;
            sync2 <= sync1;
        end
    end

`ifdef IRQ_EDGE_EN
    logic [7:0] sync3;

    // sync3 holds the previous synchronised value for rising-edge detection.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            sync3 <= 8'h00;
        end else begin
            sync3 <= sync2;
        end
    end

    assign set_vec = sync2 & ~sync3;
`else
    assign set_vec = sync2;
`endif

    //--------------------------------------------------------------------------
    // Pending and mask next-state. Setting wins over clearing, which also makes
    // a level-mode W1C ineffective while the synchronised input is still high.
    //--------------------------------------------------------------------------
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned (which would infer a latch).
    always_comb begin
        clr_vec = 8'h00;
        if (wr_en && (dp_reg == REG_PENDING)) begin
            clr_vec = wbyte;
        end
        if (ack_hit) begin
            clr_vec[IRQ_ID] = 1'b1;
        end
    end

    assign pending_nxt = (pending & ~clr_vec) | set_vec;
    assign mask_nxt    = (wr_en && (dp_reg == REG_MASK)) ? wbyte : mask;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            pending <= 8'h00;
            mask    <= 8'h00;
        end else begin
            pending <= pending_nxt;
            mask    <= mask_nxt;
        end
    end

    //--------------------------------------------------------------------------
    // Round-robin search from rr. Walking offsets downwards lets the smallest
    // offset with a request win, so no early loop exit is needed.
    //--------------------------------------------------------------------------
    assign req = pending & mask;

    always_comb begin
        logic [2:0] idx;
        idx         = 3'd0;
        grant_found = 1'b0;
        grant_idx   = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            idx = rr + 3'(i);
            if (req[idx]) begin
                grant_found = 1'b1;
                grant_idx   = idx;
            end
        end
    end

    //--------------------------------------------------------------------------
    // Grant FSM with registered IRQ_OUT / IRQ_ID. Leaving GRANT uses the
    // next-state pending/mask so a W1C or mask write drops the request on the
    // same edge it lands. Leaving GRANT always spends at least one cycle in
    // IDLE before the next grant.
    //--------------------------------------------------------------------------
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state   <= ST_IDLE;
            IRQ_OUT <= 1'b0;
            IRQ_ID  <= 3'd0;
            rr      <= 3'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant_found) begin
                        state   <= ST_GRANT;
                        IRQ_OUT <= 1'b1;
                        IRQ_ID  <= grant_idx;
                    end
                end
                ST_GRANT: begin
                    if (ack_hit) begin
                        state   <= ST_IDLE;
                        IRQ_OUT <= 1'b0;
                        rr      <= IRQ_ID + 3'd1;
                    end else if (!(pending_nxt[IRQ_ID] & mask_nxt[IRQ_ID])) begin
                        state   <= ST_IDLE;
                        IRQ_OUT <= 1'b0;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    IRQ_OUT <= 1'b0;
                end
            endcase
        end
    end

    //--------------------------------------------------------------------------
    // Read data, driven only during a read data phase.
    //--------------------------------------------------------------------------
    always_comb begin
        ahb.HRDATA = 32'h0;
        if (dp_valid && !dp_write) begin
            case (dp_reg)
                REG_PENDING: ahb.HRDATA = {24'h0, pending};
                REG_MASK:    ahb.HRDATA = {24'h0, mask};
                REG_STATUS:  ahb.HRDATA = {23'h0, IRQ_OUT, 5'h0, IRQ_ID};
                default:     ahb.HRDATA = 32'h0;
            endcase
        end
    end

    assign ahb.HREADYOUT = 1'b1;
    assign ahb.HRESP     = 1'b0;

    // Bus fields this slave does not decode.
    assign unused_bus = ^{ahb.HSIZE, ahb.HADDR[31:4], ahb.HADDR[1:0],
                          ahb.HWDATA[31:8], ahb.HTRANS[0]};

endmodule

// File: tb/tb_ahb_irq_arbiter.sv
//------------------------------------------------------------------------------
// tb_ahb_irq_arbiter
// Directed scenarios followed by randomized bus/interrupt traffic, every cycle
// compared against a behavioural model of the arbiter's rules.
//------------------------------------------------------------------------------
module tb_ahb_irq_arbiter;

    logic       HCLK = 1'b0;
    logic       HRESETn;
    logic [7:0] IRQ_IN;
    logic       IRQ_OUT;
    logic [2:0] IRQ_ID;

    int tests = 0;
    int fails = 0;

    ahb_irq_arbiter_if bus ();

    ahb_irq_arbiter dut (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .ahb     (bus),
        .IRQ_IN  (IRQ_IN),
        .IRQ_OUT (IRQ_OUT),
        .IRQ_ID  (IRQ_ID)
    );

    always #5 HCLK = ~HCLK;

    //--------------------------------------------------------------------------
    // Behavioural model
    //--------------------------------------------------------------------------
    logic [7:0] m_pending;
    logic [7:0] m_mask;
    logic [7:0] m_seen [3];   // IRQ_IN as sampled 1, 2 and 3 edges ago
    int         m_rr;
    int         m_gid;
    bit         m_granted;
    bit         m_dp_valid;
    bit         m_dp_wr;
    int         m_dp_reg;

    function void model_reset();
        m_pending  = 8'h00;
        m_mask     = 8'h00;
        for (int i = 0; i < 3; i++) m_seen[i] = 8'h00;
        m_rr       = 0;
        m_gid      = 0;
        m_granted  = 1'b0;
        m_dp_valid = 1'b0;
        m_dp_wr    = 1'b0;
        m_dp_reg   = 0;
    endfunction

    function logic [31:0] model_read(int r);
        case (r)
            0:       return {24'h0, m_pending};
            1:       return {24'h0, m_mask};
            2:       return (m_granted ? 32'h100 : 32'h0) | 32'(m_gid);
            default: return 32'h0;
        endcase
    endfunction

    // Applies one rising edge using the inputs present just before it.
    function void model_edge();
        logic [7:0] sets;
        logic [7:0] wbyte;
        logic [7:0] pend_new;
        logic [7:0] mask_new;
        logic [7:0] req;
        bit         acked;
        if (HRESETn !== 1'b1) begin
            model_reset();
            return;
        end
        // A change on IRQ_IN reaches the pending register on the third edge.
`ifdef IRQ_EDGE_EN
        sets = m_seen[1] & ~m_seen[2];
`else
        sets = m_seen[1];
`endif
        wbyte    = bus.HWDATA[7:0];
        pend_new = m_pending;
        mask_new = m_mask;
        acked    = 1'b0;
        if (m_dp_valid && m_dp_wr) begin
            case (m_dp_reg)
                0:       pend_new = pend_new & ~wbyte;
                1:       mask_new = wbyte;
                3:       acked = m_granted && (int'(wbyte[2:0]) == m_gid);
                default: ;
            endcase
        end
        if (acked) pend_new[m_gid] = 1'b0;
        pend_new = pend_new | sets;

        if (m_granted) begin
            if (acked) begin
                m_granted = 1'b0;
                m_rr      = (m_gid + 1) % 8;
            end else if (!(pend_new[m_gid] && mask_new[m_gid])) begin
                m_granted = 1'b0;
            end
        end else begin
            req = m_pending & m_mask;
            for (int k = 0; k < 8; k++) begin
                if (req[(m_rr + k) % 8]) begin
                    m_gid     = (m_rr + k) % 8;
                    m_granted = 1'b1;
                    break;
                end
            end
        end

        m_pending  = pend_new;
        m_mask     = mask_new;
        m_seen[2]  = m_seen[1];
        m_seen[1]  = m_seen[0];
        m_seen[0]  = IRQ_IN;
        m_dp_valid = bus.HSEL && bus.HREADY && bus.HTRANS[1];
        if (m_dp_valid) begin
            m_dp_wr  = bus.HWRITE;
            m_dp_reg = int'(bus.HADDR[3:2]);
        end
    endfunction

    //--------------------------------------------------------------------------
    // Checking helpers
    //--------------------------------------------------------------------------
    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic auto_check();
        check("irq_out", {31'h0, IRQ_OUT}, {31'h0, m_granted});
        check("irq_id", {29'h0, IRQ_ID}, 32'(m_gid));
        check("hrdata", bus.HRDATA,
              (m_dp_valid && !m_dp_wr) ? model_read(m_dp_reg) : 32'h0);
        check("hreadyout_hresp", {30'h0, bus.HREADYOUT, bus.HRESP}, 32'h2);
    endtask

    // One clock: model follows the rising edge, outputs compared on the falling edge.
    task automatic cycle();
        @(posedge HCLK);
        model_edge();
        @(negedge HCLK);
        auto_check();
    endtask

    //--------------------------------------------------------------------------
    // Bus drivers
    //--------------------------------------------------------------------------
    task automatic bus_idle();
        bus.HSEL   = 1'b0;
        bus.HREADY = 1'b1;
        bus.HTRANS = 2'b00;
        bus.HWRITE = 1'b0;
        bus.HSIZE  = 3'b010;
        bus.HADDR  = $urandom;
    endtask

    task automatic addr_phase(int r, bit wr);
        bus.HSEL   = 1'b1;
        bus.HREADY = 1'b1;
        bus.HTRANS = ($urandom_range(1) == 0) ? 2'b10 : 2'b11;
        bus.HWRITE = wr;
        bus.HSIZE  = 3'($urandom_range(2));
        bus.HADDR  = ($urandom & 32'hFFFF_FFF3) | (32'(r) << 2);
    endtask

    task automatic bus_write(int r, logic [7:0] d);
        addr_phase(r, 1'b1);
        cycle();
        bus_idle();
        bus.HWDATA = ($urandom & 32'hFFFF_FF00) | 32'(d);
        cycle();
    endtask

    task automatic bus_read(int r, output logic [31:0] d);
        addr_phase(r, 1'b0);
        cycle();
        d = bus.HRDATA;
        bus_idle();
    endtask

    task automatic pulse(logic [7:0] v);
        IRQ_IN = v;
        cycle();
        IRQ_IN = 8'h00;
    endtask

    task automatic wait_grant(logic [2:0] exp_id);
        int n = 0;
        while (IRQ_OUT !== 1'b1 && n < 16) begin
            cycle();
            n++;
        end
        check("grant_seen", {31'h0, IRQ_OUT}, 32'h1);
        check("grant_id", {29'h0, IRQ_ID}, {29'h0, exp_id});
    endtask

    //--------------------------------------------------------------------------
    // Stimulus
    //--------------------------------------------------------------------------
    initial begin
        logic [31:0] rd;

        // Reset with every line high
        model_reset();
        HRESETn    = 1'b0;
        IRQ_IN     = 8'hFF;
        bus.HWDATA = 32'h0;
        bus_idle();
        repeat (3) cycle();
        check("rst_irq_out", {31'h0, IRQ_OUT}, 32'h0);
        check("rst_hrdata", bus.HRDATA, 32'h0);
        IRQ_IN  = 8'h00;
        HRESETn = 1'b1;
        bus_read(0, rd);
        check("rst_pending", rd, 32'h0);
        bus_read(1, rd);
        check("rst_mask", rd, 32'h0);

        // Single source: pending on the third edge, grant one cycle later
        bus_write(1, 8'h01);
        IRQ_IN = 8'h01;
        cycle();
        addr_phase(0, 1'b0);
        cycle();
        check("pend_edge2", bus.HRDATA, 32'h0);
        addr_phase(0, 1'b0);
        cycle();
        check("pend_edge3", bus.HRDATA, 32'h1);
        check("no_grant_yet", {31'h0, IRQ_OUT}, 32'h0);
        IRQ_IN = 8'h00;
        bus_idle();
        cycle();
        check("single_irq_out", {31'h0, IRQ_OUT}, 32'h1);
        check("single_irq_id", {29'h0, IRQ_ID}, 32'h0);
        bus_write(3, 8'h00);
        check("ack_drop", {31'h0, IRQ_OUT}, 32'h0);
        bus_read(0, rd);
        check("ack_clear", rd, 32'h0);

        // Wrong ACK id leaves the grant alone
        bus_write(1, 8'hFF);
        pulse(8'h08);
        wait_grant(3'd3);
        bus_write(3, 8'h05);
        check("wrong_ack_out", {31'h0, IRQ_OUT}, 32'h1);
        check("wrong_ack_id", {29'h0, IRQ_ID}, 32'h3);
        bus_read(0, rd);
        check("wrong_ack_pend", rd, 32'h08);
        bus_write(3, 8'h03);
        check("ack3_drop", {31'h0, IRQ_OUT}, 32'h0);

        // Masking mid-grant
        pulse(8'h04);
        wait_grant(3'd2);
        bus_write(1, 8'h00);
        check("mask_drop", {31'h0, IRQ_OUT}, 32'h0);
        bus_read(0, rd);
        check("mask_pend", rd, 32'h04);
        bus_read(2, rd);
        check("mask_status_b8", {31'h0, rd[8]}, 32'h0);
        bus_write(0, 8'h04);
        bus_read(0, rd);
        check("w1c_clear", rd, 32'h0);

        // Pointer unchanged by the mask drop; then reset mid-grant
        bus_write(1, 8'hFF);
        pulse(8'h28);
        wait_grant(3'd5);
        IRQ_IN = 8'hFF;
        #2;
        HRESETn = 1'b0;
        #1;
        check("rst_async_drop", {31'h0, IRQ_OUT}, 32'h0);
        model_reset();
        repeat (2) cycle();
        IRQ_IN  = 8'h00;
        HRESETn = 1'b1;
        bus_read(0, rd);
        check("rst2_pending", rd, 32'h0);
        bus_read(1, rd);
        check("rst2_mask", rd, 32'h0);

        // Round-robin order 0,3,7 with wrap back to 0
        bus_write(1, 8'hFF);
        pulse(8'h89);
        wait_grant(3'd0);
        bus_write(3, 8'h00);
        check("rr_gap0", {31'h0, IRQ_OUT}, 32'h0);
        wait_grant(3'd3);
        bus_write(3, 8'h03);
        check("rr_gap3", {31'h0, IRQ_OUT}, 32'h0);
        wait_grant(3'd7);
        bus_write(3, 8'h07);
        check("rr_gap7", {31'h0, IRQ_OUT}, 32'h0);
        pulse(8'h81);
        wait_grant(3'd0);
        bus_write(3, 8'h00);
        wait_grant(3'd7);
        bus_write(3, 8'h07);

        // Pending set and W1C of the same bit on the same edge
        bus_write(1, 8'h00);
        IRQ_IN = 8'h01;
        cycle();
        IRQ_IN = 8'h00;
        bus_write(0, 8'h01);
        bus_read(0, rd);
        check("set_beats_w1c", {31'h0, rd[0]}, 32'h1);
        bus_write(0, 8'h01);
        bus_read(0, rd);
        check("w1c_after", rd, 32'h0);

        // Randomized traffic against the model
        bus_write(1, 8'hFF);
        for (int it = 0; it < 800; it++) begin
            if ($urandom_range(3) == 0) IRQ_IN = 8'($urandom) & 8'($urandom);
            case ($urandom_range(9))
                0, 1: bus_read(int'($urandom_range(3)), rd);
                2:    bus_write(1, 8'($urandom) | 8'($urandom));
                3:    bus_write(0, 8'($urandom));
                4, 5: bus_write(3, (m_granted && $urandom_range(3) != 0)
                                   ? 8'(m_gid) : 8'($urandom));
                6: begin
                    // Address phase while HREADY is low must be ignored
                    bus.HSEL   = 1'b1;
                    bus.HREADY = 1'b0;
                    bus.HTRANS = 2'b10;
                    bus.HWRITE = 1'b1;
                    bus.HADDR  = $urandom;
                    cycle();
                    bus_idle();
                    bus.HWDATA = $urandom;
                    cycle();
                end
                7: begin
                    // BUSY transfer must be ignored
                    addr_phase(int'($urandom_range(3)), 1'b1);
                    bus.HTRANS = 2'b01;
                    cycle();
                    bus_idle();
                    bus.HWDATA = $urandom;
                    cycle();
                end
                default: cycle();
            endcase
        end
        bus_idle();
        repeat (4) cycle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
